// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, IR handshake toward
// decode, external redirect and halt status.
interface fetch_unit_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
);
    logic [ADDR_W-1:0]  pc_out;
    logic [INSTR_W-1:0] instr_in;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    // Fetch unit side
    modport master (
        output pc_out,
        output ir_out,
        output ir_valid,
        output halted,
        input  instr_in,
        input  ir_ready,
        input  redirect,
        input  redirect_pc
    );

    // Memory / decode / branch-resolution side
    modport slave (
        input  pc_out,
        input  ir_out,
        input  ir_valid,
        input  halted,
        output instr_in,
        output ir_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage. Addresses a combinational instruction
// memory, captures the returned instruction into the IR and offers it to
// decode over valid/ready. Unconditional jumps and halts are resolved here.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_FETCH | fetching; IR loads whenever the slot is free
//  ST_HALT  | HALT captured; PC frozen until redirect or reset
module fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        OP_JMP   = 3'b100,
    parameter logic [2:0]        OP_HALT  = 3'b011
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;

    logic [0:0]         state_q,    state_d;
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [INSTR_W-1:0] ir_q,       ir_d;
    logic               ir_valid_q, ir_valid_d;

    logic               slot_free;
    logic [2:0]         opcode;
    logic [ADDR_W-1:0]  operand;

    assign slot_free = !ir_valid_q || bus.ir_ready;
    assign opcode    = bus.instr_in[INSTR_W-1 -: 3];
    assign operand   = bus.instr_in[ADDR_W-1:0];

    // Next-state decode: redirect > stall > jump > halt > normal fetch
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;

        if (bus.redirect) begin
            // In-flight IR is flushed regardless of ir_ready; a halt is lifted.
            pc_d       = bus.redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = ST_FETCH;
        end else if (state_q == ST_HALT) begin
            if (ir_valid_q && bus.ir_ready) begin
                ir_valid_d = 1'b0;
            end
        end else if (!slot_free) begin
            // Stall: decode still holds the current IR; instr_in is ignored.
        end else if (opcode == OP_JMP) begin
            pc_d       = operand;
            ir_valid_d = 1'b0;
        end else if (opcode == OP_HALT) begin
            ir_valid_d = 1'b0;
            state_d    = ST_HALT;
        end else begin
            ir_d       = bus.instr_in;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 1'b1;
        end
    end

    // State registers with synchronous reset that overrides all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.ir_out   = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(5), .INSTR_W(8)) bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [32];
    logic       rand_en = 1'b1;
    logic [7:0] rand_instr = 8'h00;

    assign bus.instr_in = rand_en ? rand_instr : mem[bus.pc_out];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int   m_pc    = 0;
    int   m_ir    = 0;
    bit   m_valid = 0;
    bit   m_halt  = 0;
    bit   model_ok = 0;

    always @(posedge clk) begin
        int op;
        int ins;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_valid = 0; m_halt = 0;
            model_ok = 1;
        end else if (model_ok) begin
            ins = int'(mem[m_pc]);
            op  = ins / 32;
            if (bus.redirect) begin
                m_pc = int'(bus.redirect_pc);
                m_valid = 0;
                m_halt = 0;
            end else if (m_halt) begin
                if (m_valid && bus.ir_ready) m_valid = 0;
            end else if (m_valid && !bus.ir_ready) begin
                // decode not ready: everything holds
            end else if (op == 4) begin
                m_pc = ins % 32;
                m_valid = 0;
            end else if (op == 3) begin
                m_valid = 0;
                m_halt = 1;
            end else begin
                m_ir = ins;
                m_valid = 1;
                m_pc = (m_pc + 1) % 32;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_pc",     32'(bus.pc_out),   32'(m_pc));
            chk("model_valid",  32'(bus.ir_valid), 32'(m_valid));
            chk("model_halted", 32'(bus.halted),   32'(m_halt));
            chk("model_ir",     32'(bus.ir_out),   32'(m_ir));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int ir, input int pc,
                              input bit v, input bit h);
        chk({nm, "_ir"},     32'(bus.ir_out),   32'(ir));
        chk({nm, "_pc"},     32'(bus.pc_out),   32'(pc));
        chk({nm, "_valid"},  32'(bus.ir_valid), 32'(v));
        chk({nm, "_halted"}, 32'(bus.halted),   32'(h));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h21;
        mem[0] = 8'h00; mem[1] = 8'h21; mem[2] = 8'hE0;
        mem[3] = 8'h22; mem[4] = 8'hE1; mem[5] = 8'h43;
        mem[6] = 8'h86;

        // Reset with random inputs
        bus.ir_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        for (int i = 0; i < 2; i++) begin
            bus.ir_ready    = 1'($urandom);
            bus.redirect    = 1'($urandom);
            bus.redirect_pc = 5'($urandom);
            rand_instr      = 8'($urandom);
            step();
        end
        expect_out("reset", 0, 0, 0, 0);

        // Stream
        rand_en = 1'b0; bus.redirect = 1'b0; bus.ir_ready = 1'b1; rst = 1'b0;
        step(); expect_out("stream0", 8'h00, 1, 1, 0);
        step(); expect_out("stream1", 8'h21, 2, 1, 0);
        step(); expect_out("stream2", 8'hE0, 3, 1, 0);

        // Backpressure
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("stall", 8'hE0, 3, 1, 0);
        end
        bus.ir_ready = 1'b1;
        step(); expect_out("resume3", 8'h22, 4, 1, 0);
        step(); expect_out("resume4", 8'hE1, 5, 1, 0);
        step(); expect_out("resume5", 8'h43, 6, 1, 0);

        // Jump to self, then jump back to 2
        for (int i = 0; i < 4; i++) begin
            step(); expect_out("jmp_self", 8'h43, 6, 0, 0);
        end
        mem[6] = 8'h82;
        step(); expect_out("jmp2_bubble", 8'h43, 2, 0, 0);
        step(); expect_out("jmp2_target", 8'hE0, 3, 1, 0);

        // Halt then redirect
        mem[3] = 8'h60;
        step(); expect_out("halt", 8'hE0, 3, 0, 1);
        step(); expect_out("halt_hold", 8'hE0, 3, 0, 1);
        bus.redirect = 1'b1; bus.redirect_pc = 5'd0;
        step(); expect_out("redir_halt", 8'hE0, 0, 0, 0);
        bus.redirect = 1'b0; mem[3] = 8'h22;
        step(); expect_out("redir_fetch", 8'h00, 1, 1, 0);

        // Redirect during a stall flushes the IR
        bus.ir_ready = 1'b0;
        step(); expect_out("stall2", 8'h00, 1, 1, 0);
        bus.redirect = 1'b1; bus.redirect_pc = 5'd5;
        step(); expect_out("redir_stall", 8'h00, 5, 0, 0);

        // PC wrap 31 -> 0
        bus.ir_ready = 1'b1; bus.redirect_pc = 5'd31;
        step(); expect_out("to31", 8'h00, 31, 0, 0);
        bus.redirect = 1'b0;
        step(); expect_out("wrap", 8'h21, 0, 1, 0);
        step(); expect_out("after_wrap", 8'h00, 1, 1, 0);

        // Reset mid-stream
        rst = 1'b1;
        step(); expect_out("mid_reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Randomized phase
        for (int i = 0; i < 32; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      mem[i] = {3'b100, 5'($urandom)};
            else if (r == 1) mem[i] = 8'h60 | 8'($urandom_range(0, 31));
            else begin
                logic [2:0] op;
                op = 3'($urandom);
                if (op == 3'b100 || op == 3'b011) op = 3'b001;
                mem[i] = {op, 5'($urandom)};
            end
        end
        for (int c = 0; c < 3000; c++) begin
            bus.ir_ready    = ($urandom_range(0, 9) < 7);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = 5'($urandom);
            rst             = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 49) == 0) mem[$urandom_range(0, 31)] = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
